serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 18 +
 rtl/serial_add_sub_full_adder_cell.sv | 15 +
 rtl/serial_add_sub.sv | 113 +++++++++++
 tb/tb_serial_add_sub.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// State encodings and mode constants are fixed so other tools can decode them.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder_cell.sv
// Single-bit full adder; the only arithmetic cell in the serial datapath.
module full_adder_cell
  import serial_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one operand pair in, WIDTH clocks of LSB-first
// addition through a single full adder, result held until the consumer takes it.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cbout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_PRE_MSB = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_MSB     = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c;
  logic             c_msb;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             c_next;
  logic             sub;

  assign sub = (en == MODE_SUB);

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c),
    .s    (s),
    .cout (c_next)
  );

  // The result shifts into the top of a_sh as operand A bits drain out of the
  // bottom, so after WIDTH shifts a_sh holds the complete sum.
  // NOTE: every register, including the shift registers, is reset so an
  // aborted operation leaves no residue; state uses non-blocking assignments
  // only, so all branches see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cbout     <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      c         <= 1'b0;
      c_msb     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            a_sh     <= A;
            b_sh     <= B ^ {WIDTH{sub}};
            c        <= sub;
            c_msb    <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          a_sh <= {s, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          c    <= c_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_PRE_MSB) begin
            c_msb <= c_next;
          end
          if (cnt == CNT_MSB) begin
            sum       <= {s, a_sh[WIDTH-1:1]};
            cbout     <= c_next;
            ovf       <= c_msb ^ c_next;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed-vector bench for serial_add_sub (WIDTH=4) with hand-computed results.
module tb_serial_add_sub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cbout;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc[$];
  int hs_cyc[$];

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cbout     (cbout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Edge log, sampled with pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) accept_cyc.push_back(cyc);
    if (rst_n && out_valid && out_ready) hs_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s_ready_timeout: in_ready=%b want 1", name, in_ready);
    end
  endtask

  // Accepts one operation and counts edges until out_valid rises.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic e,
                        output int lat);
    A = a; B = b; en = e; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; en = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++;
    if ({out_valid, sum, cbout, ovf} !== 7'b0) begin
      errors++;
      $display("FAIL rst_outputs: got ov=%b sum=%b cb=%b ovf=%b want all 0", out_valid, sum, cbout, ovf);
    end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_early: in_ready=%b want 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_add_overflow();
    int lat;
    wait_ready("add");
    run_op(4'b0100, 4'b0111, 1'b0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++;
    if ({sum, cbout, ovf} !== {4'b1011, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_result: got sum=%b cb=%b ovf=%b want 1011 0 1", sum, cbout, ovf);
    end
    release_result();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL add_handshake: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_sub();
    int lat;
    wait_ready("sub1");
    run_op(4'b0110, 4'b1111, 1'b1, lat);
    checks++;
    if ({out_valid, sum, cbout, ovf} !== {1'b1, 4'b0111, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub1_result: got ov=%b sum=%b cb=%b ovf=%b want 1 0111 0 0", out_valid, sum, cbout, ovf);
    end
    release_result();
    wait_ready("sub2");
    run_op(4'b0101, 4'b0011, 1'b1, lat);
    checks++;
    if ({out_valid, sum, cbout, ovf} !== {1'b1, 4'b0010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub2_result: got ov=%b sum=%b cb=%b ovf=%b want 1 0010 1 0", out_valid, sum, cbout, ovf);
    end
    release_result();
  endtask

  task automatic test_hold_and_ignore();
    int n = 0;
    wait_ready("hold");
    A = 4'b1000; B = 4'b0111; en = 1'b0; in_valid = 1'b1;
    tick();
    A = 4'b0001; B = 4'b0000;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready, sum, cbout, ovf} !== {1'b1, 1'b0, 4'b1111, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ov=%b ir=%b sum=%b cb=%b ovf=%b want 1 0 1111 0 0",
                 i, out_valid, in_ready, sum, cbout, ovf);
      end
      tick();
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL hold_after_release: got ov=%b ir=%b sum=%b want 0 1 1111", out_valid, in_ready, sum);
    end
  endtask

  task automatic test_input_change();
    int n = 0;
    wait_ready("chg");
    A = 4'b0001; B = 4'b0000; en = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; A = 4'b1111; B = 4'b1111; en = 1'b0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if ({out_valid, sum, cbout, ovf} !== {1'b1, 4'b0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL chg_result: got ov=%b sum=%b cb=%b ovf=%b want 1 0001 1 0", out_valid, sum, cbout, ovf);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    wait_ready("b2b");
    accept_cyc.delete();
    hs_cyc.delete();
    A = 4'b0000; B = 4'b0101; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    A = 4'b0001; B = 4'b0001; en = 1'b0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    if ({out_valid, sum, cbout, ovf} !== {1'b1, 4'b1011, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: got ov=%b sum=%b cb=%b ovf=%b want 1 1011 0 0", out_valid, sum, cbout, ovf);
    end
    tick();
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    if ({out_valid, sum, cbout, ovf} !== {1'b1, 4'b0010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: got ov=%b sum=%b cb=%b ovf=%b want 1 0010 0 0", out_valid, sum, cbout, ovf);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (accept_cyc.size() < 2 || hs_cyc.size() < 1) begin
      errors++;
      $display("FAIL b2b_events: accepts=%0d handshakes=%0d want >=2 >=1", accept_cyc.size(), hs_cyc.size());
    end else begin
      checks++;
      if (accept_cyc[1] - accept_cyc[0] !== 6) begin
        errors++;
        $display("FAIL b2b_period: got %0d want 6", accept_cyc[1] - accept_cyc[0]);
      end
      checks++;
      if (accept_cyc[1] - hs_cyc[0] !== 1) begin
        errors++;
        $display("FAIL b2b_reaccept: got %0d edges after handshake want 1", accept_cyc[1] - hs_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen = 1'b0;
    wait_ready("abort");
    A = 4'b0011; B = 4'b0100; en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sum, cbout, ovf} !== 8'b0) begin
      errors++;
      $display("FAIL abort_reset: got ov=%b ir=%b sum=%b cb=%b ovf=%b want all 0",
               out_valid, in_ready, sum, cbout, ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: in_ready=%b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || sum !== 4'b0000) begin
      errors++;
      $display("FAIL abort_no_result: out_valid seen=%b sum=%b want 0 0000", seen, sum);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_hold_and_ignore();
    test_input_change();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
